// File: rtl/sar_pkg.sv
// Shared types and helpers for the SAR code register.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sar_pkg;

    localparam int SAR_N_BITS = 12;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        ERR  = 2'd2
    } sar_state_t;

    localparam logic [SAR_N_BITS-1:0] MIDSCALE = {1'b1, {(SAR_N_BITS-1){1'b0}}};

    function automatic logic is_onehot(input logic [31:0] v);
        return (v != 32'd0) && ((v & (v - 32'd1)) == 32'd0);
    endfunction

    function automatic logic [4:0] onehot_idx(input logic [31:0] v);
        logic [4:0] r;
        r = '0;
        for (int i = 0; i < 32; i++) begin
            if (v[i]) r = 5'(i);
        end
        return r;
    endfunction

endpackage

// File: rtl/flag_edge_check.sv
// Registers the phase flags and reports rising/falling bits plus a one-hot index.
// Latency: outputs are combinational against the one-cycle-old flag copy.
// Backpressure: none; flags are sampled every cycle.
module flag_edge_check
    import sar_pkg::*;
#(
    parameter int N_BITS = SAR_N_BITS,
    localparam int IDX_W = $clog2(N_BITS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_BITS-1:0] flag,
    output logic [N_BITS-1:0] new_bits,
    output logic [N_BITS-1:0] fall_bits,
    output logic              onehot,
    output logic [IDX_W-1:0]  idx
);

    logic [N_BITS-1:0] flag_q;
    logic [N_BITS-1:0] flag_d;

    always_comb begin
        flag_d    = flag;
        new_bits  = flag & ~flag_q;
        fall_bits = flag_q & ~flag;
        onehot    = is_onehot(32'(new_bits));
        idx       = IDX_W'(onehot_idx(32'(new_bits)));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) flag_q <= '0;
        else        flag_q <= flag_d;
    end

endmodule

// File: rtl/sar_code_register.sv
// SAR working register: samples COMP on each new phase flag, drives the DAC trial word.
// Latency: DOUT_VALID rises the cycle after FLAG[0] is first seen high.
// Backpressure: DOUT held until DOUT_READY; a newer result overwrites it and pulses OVR.
module sar_code_register
    import sar_pkg::*;
#(
    parameter int N_BITS = SAR_N_BITS
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic [N_BITS-1:0] FLAG,
    input  logic              COMP,
    output logic [N_BITS-1:0] DAC_CTRL,
    output logic [N_BITS-1:0] DOUT,
    output logic              DOUT_VALID,
    input  logic              DOUT_READY,
    output logic              BUSY,
    output logic              SEQ_ERR,
    output logic              OVR
);

    localparam int                IDX_W   = $clog2(N_BITS);
    localparam logic [IDX_W-1:0]  PTR_TOP = IDX_W'(N_BITS - 1);
    localparam logic [N_BITS-1:0] MID     = {1'b1, {(N_BITS-1){1'b0}}};

    logic [N_BITS-1:0] new_bits;
    logic [N_BITS-1:0] fall_bits;
    logic              onehot;
    logic [IDX_W-1:0]  idx;

    flag_edge_check #(.N_BITS(N_BITS)) u_edge (
        .clk       (CLK),
        .rst_n     (RST_N),
        .flag      (FLAG),
        .new_bits  (new_bits),
        .fall_bits (fall_bits),
        .onehot    (onehot),
        .idx       (idx)
    );

    sar_state_t        state_q, state_d;
    logic [IDX_W-1:0]  ptr_q, ptr_d;
    logic [N_BITS-1:0] work_q, work_d;
    logic [N_BITS-1:0] dac_q, dac_d;
    logic [N_BITS-1:0] dout_q, dout_d;
    logic              dout_vld_q, dout_vld_d;
    logic              busy_q, busy_d;
    logic              seq_err_q, seq_err_d;
    logic              ovr_q, ovr_d;

    logic flag_zero;
    logic step_ok;
    logic violation;

    always_comb begin
        flag_zero  = (FLAG == '0);
        step_ok    = onehot && (idx == ptr_q) && (fall_bits == '0);
        violation  = ((new_bits != '0) && !(onehot && (idx == ptr_q))) || (fall_bits != '0);

        state_d    = state_q;
        ptr_d      = ptr_q;
        work_d     = work_q;
        dac_d      = dac_q;
        busy_d     = busy_q;
        seq_err_d  = 1'b0;
        ovr_d      = 1'b0;
        dout_d     = dout_q;
        dout_vld_d = dout_vld_q && !DOUT_READY;

        case (state_q)
            IDLE, CONV: begin
                // All-zero flags mean the generator restarted: abort quietly.
                if (flag_zero) begin
                    state_d = IDLE;
                    ptr_d   = PTR_TOP;
                    work_d  = '0;
                    dac_d   = MID;
                    busy_d  = 1'b0;
                end else if (violation) begin
                    state_d   = ERR;
                    seq_err_d = 1'b1;
                    ptr_d     = PTR_TOP;
                    work_d    = '0;
                    dac_d     = MID;
                    busy_d    = 1'b0;
                end else if (step_ok) begin
                    state_d     = CONV;
                    work_d[idx] = COMP;
                    dac_d[idx]  = COMP;
                    if (idx != '0) begin
                        dac_d[idx - IDX_W'(1)] = 1'b1;
                        ptr_d  = idx - IDX_W'(1);
                        busy_d = 1'b1;
                    end else begin
                        // Final bit: publish the code; DAC keeps it until flags clear.
                        busy_d     = 1'b0;
                        dout_d     = {work_q[N_BITS-1:1], COMP};
                        ovr_d      = dout_vld_q && !DOUT_READY;
                        dout_vld_d = 1'b1;
                    end
                end
            end
            ERR: begin
                if (flag_zero) begin
                    state_d = IDLE;
                    ptr_d   = PTR_TOP;
                    dac_d   = MID;
                end
            end
            default: begin
                state_d = IDLE;
                ptr_d   = PTR_TOP;
                dac_d   = MID;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q    <= IDLE;
            ptr_q      <= PTR_TOP;
            work_q     <= '0;
            dac_q      <= MID;
            dout_q     <= '0;
            dout_vld_q <= 1'b0;
            busy_q     <= 1'b0;
            seq_err_q  <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            work_q     <= work_d;
            dac_q      <= dac_d;
            dout_q     <= dout_d;
            dout_vld_q <= dout_vld_d;
            busy_q     <= busy_d;
            seq_err_q  <= seq_err_d;
            ovr_q      <= ovr_d;
        end
    end

    assign DAC_CTRL   = dac_q;
    assign DOUT       = dout_q;
    assign DOUT_VALID = dout_vld_q;
    assign BUSY       = busy_q;
    assign SEQ_ERR    = seq_err_q;
    assign OVR        = ovr_q;

endmodule
